// File: rtl/disp_arb.sv
// disp_arb: two-source round-robin display arbiter.
// A granted value is driven to the display for HOLD_CYCLES clocks. At least
// one IDLE cycle separates two grants. On a tie, the source that was not
// served last wins.
//
// Parameters:
//   HOLD_CYCLES  number of HOLD cycles per grant (1..65535)
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req_fib      Fibonacci-source request (level, held until granted)
//   data_fib     Fibonacci-source value
//   req_tmr      Timer-source request (level, held until granted)
//   data_tmr     Timer-source value
//   gnt_fib      one-cycle grant pulse to the Fibonacci source
//   gnt_tmr      one-cycle grant pulse to the Timer source
//   data_2       value currently driven to the display manager
//   modulo       source tag: 0 none, 1 Fibonacci, 2 Timer
//   busy         high while a value is being held
// Build option:
//   DISP_ARB_BLANK_EN  clear data_2/modulo when HOLD returns to IDLE
module disp_arb #(
    parameter int unsigned HOLD_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_fib,
    input  logic [15:0] data_fib,
    input  logic        req_tmr,
    input  logic [15:0] data_tmr,
    output logic        gnt_fib,
    output logic        gnt_tmr,
    output logic [15:0] data_2,
    output logic [1:0]  modulo,
    output logic        busy
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned MOD_W  = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [MOD_W-1:0] TAG_NONE = MOD_W'(0);
    localparam logic [MOD_W-1:0] TAG_FIB  = MOD_W'(1);
    localparam logic [MOD_W-1:0] TAG_TMR  = MOD_W'(2);

    // Last-served pointer encoding
    localparam logic LAST_FIB = 1'b0;
    localparam logic LAST_TMR = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [MOD_W-1:0]    mod_q, mod_d;
    logic                gnt_fib_q, gnt_fib_d;
    logic                gnt_tmr_q, gnt_tmr_d;
    logic                busy_q, busy_d;
    logic                pick_fib_c;
    logic                pick_tmr_c;

    // Round-robin pick: Fibonacci wins unless Timer also requests and Fibonacci was served last
    always_comb begin
        pick_fib_c = req_fib && (!req_tmr || (last_q == LAST_TMR));
        pick_tmr_c = req_tmr && !pick_fib_c;
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        data_d    = data_q;
        mod_d     = mod_q;
        gnt_fib_d = 1'b0;
        gnt_tmr_d = 1'b0;
        busy_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_fib_c) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    last_d    = LAST_FIB;
                    data_d    = data_fib;
                    mod_d     = TAG_FIB;
                    gnt_fib_d = 1'b1;
                    busy_d    = 1'b1;
                end else if (pick_tmr_c) begin
                    state_d   = HOLD;
                    cnt_d     = '0;
                    last_d    = LAST_TMR;
                    data_d    = data_tmr;
                    mod_d     = TAG_TMR;
                    gnt_tmr_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            HOLD: begin
                // Requests are ignored here; the counter stops at CNT_LAST so it never wraps
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef DISP_ARB_BLANK_EN
                    data_d  = '0;
                    mod_d   = TAG_NONE;
`endif
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= LAST_TMR;
            data_q    <= '0;
            mod_q     <= TAG_NONE;
            gnt_fib_q <= 1'b0;
            gnt_tmr_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            data_q    <= data_d;
            mod_q     <= mod_d;
            gnt_fib_q <= gnt_fib_d;
            gnt_tmr_q <= gnt_tmr_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt_fib = gnt_fib_q;
    assign gnt_tmr = gnt_tmr_q;
    assign data_2  = data_q;
    assign modulo  = mod_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_disp_arb.sv
// Directed testbench for disp_arb with HOLD_CYCLES=4.
module tb_disp_arb;

    localparam int unsigned HOLD = 4;

`ifdef DISP_ARB_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_fib;
    logic [15:0] data_fib;
    logic        req_tmr;
    logic [15:0] data_tmr;
    logic        gnt_fib;
    logic        gnt_tmr;
    logic [15:0] data_2;
    logic [1:0]  modulo;
    logic        busy;

    disp_arb #(.HOLD_CYCLES(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_fib  (req_fib),
        .data_fib (data_fib),
        .req_tmr  (req_tmr),
        .data_tmr (data_tmr),
        .gnt_fib  (gnt_fib),
        .gnt_tmr  (gnt_tmr),
        .data_2   (data_2),
        .modulo   (modulo),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rf;
        logic [15:0] df;
        logic        rt;
        logic [15:0] dt;
        logic        gf;
        logic        gt;
        logic [15:0] d;
        logic [1:0]  m;
        logic        b;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic rf, input logic [15:0] df,
                       input logic rt, input logic [15:0] dt,
                       input logic gf, input logic gt, input logic [15:0] d,
                       input logic [1:0] m, input logic b);
        vec_t v;
        v.rst = r; v.rf = rf; v.df = df; v.rt = rt; v.dt = dt;
        v.gf = gf; v.gt = gt; v.d = d; v.m = m; v.b = b;
        vq.push_back(v);
    endtask

    // Value left on the display after a hold ends
    function automatic logic [15:0] ret_d(input logic [15:0] d);
        return BLANK ? 16'h0000 : d;
    endfunction

    function automatic logic [1:0] ret_m(input logic [1:0] m);
        return BLANK ? 2'd0 : m;
    endfunction

    task automatic check(input string name, input logic gf, input logic gt,
                         input logic [15:0] d, input logic [1:0] m, input logic b);
        checks++;
        if ({gnt_fib, gnt_tmr, data_2, modulo, busy} !== {gf, gt, d, m, b}) begin
            failures++;
            $display("FAIL %s: got gf=%b gt=%b d=%h m=%0d b=%b, want gf=%b gt=%b d=%h m=%0d b=%b",
                     name, gnt_fib, gnt_tmr, data_2, modulo, busy, gf, gt, d, m, b);
        end
        checks++;
        if (gnt_fib && gnt_tmr) begin
            failures++;
            $display("FAIL %s_excl: got both grants high, want at most one", name);
        end
    endtask

    initial begin
        rst = 1'b0; req_fib = 1'b0; data_fib = '0; req_tmr = 1'b0; data_tmr = '0;
        #1;
        check("reset_t0", 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0);

        // Single Fibonacci request
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 2'd0, 0);
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 2'd0, 0);
        add(1, 1, 16'h0377, 0, 16'h0000, 1, 0, 16'h0377, 2'd1, 1);
        for (int i = 0; i < 3; i++)
            add(1, 0, 16'h0377, 0, 16'h0000, 0, 0, 16'h0377, 2'd1, 1);
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, ret_d(16'h0377), ret_m(2'd1), 0);

        // Tie from reset, then both held: fib, tmr, fib, tmr every 5 cycles
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                add(1, 1, 16'h0001, 1, 16'h1234, 1, 0, 16'h0001, 2'd1, 1);
            else
                add(1, 1, 16'h0001, 1, 16'h1234, 0, 1, 16'h1234, 2'd2, 1);
            if (k < 3) begin
                for (int i = 0; i < 3; i++)
                    add(1, 1, 16'h0001, 1, 16'h1234, 0, 0,
                        (k % 2 == 0) ? 16'h0001 : 16'h1234, (k % 2 == 0) ? 2'd1 : 2'd2, 1);
                add(1, 1, 16'h0001, 1, 16'h1234, 0, 0,
                    ret_d((k % 2 == 0) ? 16'h0001 : 16'h1234),
                    ret_m((k % 2 == 0) ? 2'd1 : 2'd2), 0);
            end
        end
        for (int i = 0; i < 3; i++)
            add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h1234, 2'd2, 1);
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, ret_d(16'h1234), ret_m(2'd2), 0);

        // Late Timer request during a Fibonacci hold, then blanking check
        add(1, 1, 16'h0377, 0, 16'h0000, 1, 0, 16'h0377, 2'd1, 1);
        for (int i = 0; i < 3; i++)
            add(1, 0, 16'h0000, 1, 16'h00AB, 0, 0, 16'h0377, 2'd1, 1);
        add(1, 0, 16'h0000, 1, 16'h00AB, 0, 0, ret_d(16'h0377), ret_m(2'd1), 0);
        add(1, 0, 16'h0000, 1, 16'h00AB, 0, 1, 16'h00AB, 2'd2, 1);
        for (int i = 0; i < 3; i++)
            add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h00AB, 2'd2, 1);
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, ret_d(16'h00AB), ret_m(2'd2), 0);
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, ret_d(16'h00AB), ret_m(2'd2), 0);

        // Request still high after its hold is a new request
        add(1, 1, 16'h0377, 0, 16'h0000, 1, 0, 16'h0377, 2'd1, 1);
        for (int i = 0; i < 3; i++)
            add(1, 1, 16'h0377, 0, 16'h0000, 0, 0, 16'h0377, 2'd1, 1);
        add(1, 1, 16'h0377, 0, 16'h0000, 0, 0, ret_d(16'h0377), ret_m(2'd1), 0);
        add(1, 1, 16'h0377, 0, 16'h0000, 1, 0, 16'h0377, 2'd1, 1);
        for (int i = 0; i < 3; i++)
            add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0377, 2'd1, 1);
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 0, ret_d(16'h0377), ret_m(2'd1), 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; req_fib = vq[i].rf; data_fib = vq[i].df;
            req_tmr = vq[i].rt; data_tmr = vq[i].dt;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vq[i].gf, vq[i].gt, vq[i].d, vq[i].m, vq[i].b);
        end

        // Reset in the middle of a hold aborts it immediately
        @(negedge clk);
        req_fib = 1'b1; data_fib = 16'h0377;
        @(posedge clk); #1;
        check("mh_grant", 1'b1, 1'b0, 16'h0377, 2'd1, 1'b1);
        @(negedge clk);
        req_fib = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mh_cyc2", 1'b0, 1'b0, 16'h0377, 2'd1, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mh_async", 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("mh_post%0d", i), 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
